sub_bytes_iter: RTL and testbench

SUB_BYTES_ITER -- requirements
Module: sub_bytes_iter

---
 rtl/aes_pkg.sv | 14 +
 rtl/aes_sbox.sv | 46 ++++
 rtl/sub_bytes_iter.sv | 117 +++++++++++
 tb/tb_sub_bytes_iter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types: FSM state encoding, byte type and state size.
package aes_pkg;

  localparam int unsigned AES_BYTES = 16;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box lane; the inverse table and the inv select exist
// only when SUB_BYTES_INV_EN is defined.
module aes_sbox
  import aes_pkg::*;
(
`ifdef SUB_BYTES_INV_EN
  input  logic  inv,
`endif
  input  byte_t data,
  output byte_t subst
);

  // Entry 0x00 occupies the top byte, so entry x sits at bit offset 8*(255-x) = {~x, 3'b000}.
  localparam logic [2047:0] FWD_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

`ifdef SUB_BYTES_INV_EN
  localparam logic [2047:0] INV_TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  always_comb begin
    subst = inv ? INV_TABLE[{~data, 3'b000} +: 8] : FWD_TABLE[{~data, 3'b000} +: 8];
  end
`else
  always_comb begin
    subst = FWD_TABLE[{~data, 3'b000} +: 8];
  end
`endif

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: SBOX_LANES bytes substituted in place per cycle.
// Optional inverse substitution via the SUB_BYTES_INV_EN macro.
module sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int unsigned SBOX_LANES = 4
) (
`ifdef SUB_BYTES_INV_EN
  input  logic         inv,
`endif
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out
);

  localparam int unsigned NUM_BEATS = AES_BYTES / SBOX_LANES;
  localparam int unsigned BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

  state_t            state;
  state_t            state_next;
  logic [BEAT_W-1:0] beat;
  logic [127:0]      data_q;
  logic [127:0]      data_nxt;
  logic              load;
  logic              step;
  byte_t             cur      [AES_BYTES];
  byte_t             nxt      [AES_BYTES];
  byte_t             lane_in  [SBOX_LANES];
  byte_t             lane_out [SBOX_LANES];

`ifdef SUB_BYTES_INV_EN
  logic inv_q;
`endif

  for (genvar g = 0; g < AES_BYTES; g++) begin : g_bytes
    assign cur[g] = data_q[(AES_BYTES-1-g)*8 +: 8];
    assign data_nxt[(AES_BYTES-1-g)*8 +: 8] = nxt[g];
  end

  // Lane l of beat k works on byte k*SBOX_LANES + l (byte 0 is the MSB).
  always_comb begin
    logic [3:0] pos;
    nxt = cur;
    for (int unsigned l = 0; l < SBOX_LANES; l++) begin
      pos        = 4'(beat * SBOX_LANES + l);
      lane_in[l] = cur[pos];
      nxt[pos]   = lane_out[l];
    end
  end

  for (genvar g = 0; g < SBOX_LANES; g++) begin : g_lane
    aes_sbox u_sbox (
`ifdef SUB_BYTES_INV_EN
      .inv   (inv_q),
`endif
      .data  (lane_in[g]),
      .subst (lane_out[g])
    );
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          load       = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (beat == LAST_BEAT) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat   <= '0;
      data_q <= '0;
`ifdef SUB_BYTES_INV_EN
      inv_q  <= 1'b0;
`endif
    end else if (load) begin
      beat   <= '0;
      data_q <= data_in;
`ifdef SUB_BYTES_INV_EN
      inv_q  <= inv;
`endif
    end else if (step) begin
      beat   <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
      data_q <= data_nxt;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign data_out  = data_q;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Directed bench for sub_bytes_iter at SBOX_LANES = 4, 1 and 16 side by side.
// Inverse-mode checks compile in when SUB_BYTES_INV_EN is defined.
module tb_sub_bytes_iter;

  localparam logic [127:0] ZERO_OUT = {16{8'h63}};
  localparam logic [127:0] VEC_IN   = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] VEC_OUT  = 128'h63cab7040953d051cd60e0e7ba70e18c;
  localparam logic [127:0] B53      = {16{8'h53}};
  localparam logic [127:0] BED      = {16{8'hed}};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] data_in;
  logic [2:0]   in_ready;
  logic [2:0]   out_valid;
  logic [127:0] data_out [3];
`ifdef SUB_BYTES_INV_EN
  logic         inv;
`endif

  int lanes [3] = '{4, 1, 16};
  int lat   [3] = '{5, 17, 2};

  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  always #5 clk = ~clk;

  sub_bytes_iter #(.SBOX_LANES(4)) u_l4 (
`ifdef SUB_BYTES_INV_EN
    .inv(inv),
`endif
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
    .data_in(data_in), .out_valid(out_valid[0]), .out_ready(out_ready), .data_out(data_out[0])
  );

  sub_bytes_iter #(.SBOX_LANES(1)) u_l1 (
`ifdef SUB_BYTES_INV_EN
    .inv(inv),
`endif
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
    .data_in(data_in), .out_valid(out_valid[1]), .out_ready(out_ready), .data_out(data_out[1])
  );

  sub_bytes_iter #(.SBOX_LANES(16)) u_l16 (
`ifdef SUB_BYTES_INV_EN
    .inv(inv),
`endif
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
    .data_in(data_in), .out_valid(out_valid[2]), .out_ready(out_ready), .data_out(data_out[2])
  );

  // Returns at a falling edge with every instance idle, or flags a timeout.
  task automatic wait_all_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(&in_ready) && n < 40);
    if (!(&in_ready)) begin
      compared++;
      mismatched++;
      $display("FAIL %s idle_timeout: in_ready=%b expected 111", name, in_ready);
    end
  endtask

  task automatic run_block(input string name, input logic [127:0] din, input logic [127:0] exp);
    int           first [3];
    int           highs [3];
    logic [127:0] got   [3];
    wait_all_idle(name);
    out_ready = 1'b1;
    data_in   = din;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data_in  = '1;
    for (int d = 0; d < 3; d++) begin
      first[d] = -1;
      highs[d] = 0;
      got[d]   = '0;
    end
    for (int cyc = 1; cyc <= 25; cyc++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (out_valid[d] === 1'b1) begin
          highs[d]++;
          if (first[d] < 0) begin
            first[d] = cyc;
            got[d]   = data_out[d];
          end
        end
      end
    end
    for (int d = 0; d < 3; d++) begin
      compared++;
      if (first[d] !== lat[d]) begin
        mismatched++;
        $display("FAIL %s lanes=%0d latency: got %0d expected %0d", name, lanes[d], first[d], lat[d]);
      end
      compared++;
      if (got[d] !== exp) begin
        mismatched++;
        $display("FAIL %s lanes=%0d data_out: got %h expected %h", name, lanes[d], got[d], exp);
      end
      compared++;
      if (highs[d] !== 1) begin
        mismatched++;
        $display("FAIL %s lanes=%0d valid_cycles: got %0d expected 1", name, lanes[d], highs[d]);
      end
    end
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    data_in   = '0;
`ifdef SUB_BYTES_INV_EN
    inv       = 1'b0;
`endif
    #2;
    for (int d = 0; d < 3; d++) begin
      compared++;
      if (in_ready[d] !== 1'b1) begin
        mismatched++;
        $display("FAIL reset lanes=%0d in_ready: got %b expected 1", lanes[d], in_ready[d]);
      end
      compared++;
      if (out_valid[d] !== 1'b0) begin
        mismatched++;
        $display("FAIL reset lanes=%0d out_valid: got %b expected 0", lanes[d], out_valid[d]);
      end
      compared++;
      if (data_out[d] !== 128'h0) begin
        mismatched++;
        $display("FAIL reset lanes=%0d data_out: got %h expected 0", lanes[d], data_out[d]);
      end
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_block;
    int spurious = 0;
    wait_all_idle("mid_reset");
    data_in  = VEC_IN;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      compared++;
      if (out_valid[d] !== 1'b0 || data_out[d] !== 128'h0 || in_ready[d] !== 1'b1) begin
        mismatched++;
        $display("FAIL mid_reset lanes=%0d async_clear: valid=%b ready=%b data=%h expected valid=0 ready=1 data=0",
                 lanes[d], out_valid[d], in_ready[d], data_out[d]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (out_valid !== 3'b000) spurious++;
    end
    compared++;
    if (spurious !== 0) begin
      mismatched++;
      $display("FAIL mid_reset spurious_valid: got %0d cycles expected 0", spurious);
    end
    run_block("after_reset", VEC_IN, VEC_OUT);
  endtask

  task automatic test_backpressure;
    int n = 0;
    wait_all_idle("backpressure");
    out_ready = 1'b0;
    data_in   = B53;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (out_valid[0] !== 1'b1 && n < 20);
    compared++;
    if (n !== 5) begin
      mismatched++;
      $display("FAIL backpressure first_valid: got cycle %0d expected 5", n);
    end
    for (int k = 0; k < 10; k++) begin
      in_valid = (k % 2 == 0);
      data_in  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      compared++;
      if (out_valid[0] !== 1'b1 || data_out[0] !== BED || in_ready[0] !== 1'b0 ||
          out_valid[2] !== 1'b1 || data_out[2] !== BED) begin
        mismatched++;
        $display("FAIL backpressure hold k=%0d: valid=%b ready=%b data=%h expected valid=1 ready=0 data=%h",
                 k, out_valid[0], in_ready[0], data_out[0], BED);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    compared++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      mismatched++;
      $display("FAIL backpressure release: valid=%b ready=%b expected valid=0 ready=1", out_valid[0], in_ready[0]);
    end
    n = 0;
    while (out_valid[1] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (out_valid[1] !== 1'b1 || data_out[1] !== BED) begin
      mismatched++;
      $display("FAIL backpressure lanes=1 data_out: valid=%b data=%h expected valid=1 data=%h",
               out_valid[1], data_out[1], BED);
    end
  endtask

  task automatic test_back_to_back;
    int acc   [3][2];
    int nacc  [3];
    int exp_gap;
    wait_all_idle("back_to_back");
    for (int d = 0; d < 3; d++) nacc[d] = 0;
    out_ready = 1'b1;
    data_in   = '0;
    in_valid  = 1'b1;
    for (int cyc = 0; cyc < 45; cyc++) begin
      for (int d = 0; d < 3; d++) begin
        if (in_ready[d] === 1'b1 && nacc[d] < 2) begin
          acc[d][nacc[d]] = cyc;
          nacc[d]++;
        end
        if (out_valid[d] === 1'b1) begin
          compared++;
          if (data_out[d] !== ZERO_OUT) begin
            mismatched++;
            $display("FAIL back_to_back lanes=%0d data_out: got %h expected %h", lanes[d], data_out[d], ZERO_OUT);
          end
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int d = 0; d < 3; d++) begin
      exp_gap = lat[d] + 1;
      compared++;
      if (nacc[d] !== 2 || acc[d][1] - acc[d][0] !== exp_gap) begin
        mismatched++;
        $display("FAIL back_to_back lanes=%0d issue_interval: got %0d (accepts=%0d) expected %0d",
                 lanes[d], (nacc[d] == 2) ? acc[d][1] - acc[d][0] : -1, nacc[d], exp_gap);
      end
    end
    wait_all_idle("back_to_back_drain");
  endtask

`ifdef SUB_BYTES_INV_EN
  task automatic test_inverse;
    inv = 1'b1;
    run_block("inv_63", ZERO_OUT, 128'h0);
    inv = 1'b0;
    run_block("fwd_53", B53, BED);
    inv = 1'b1;
    run_block("inv_ed", BED, B53);
    inv = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    run_block("all_zero", 128'h0, ZERO_OUT);
    run_block("vector", VEC_IN, VEC_OUT);
    test_backpressure();
    test_reset_mid_block();
    test_back_to_back();
`ifdef SUB_BYTES_INV_EN
    test_inverse();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
